// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;
   localparam int unsigned XLEN       = 32;
   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HALTED = 2'd1,
      FAULT  = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/fetch_slot.sv
// Single-entry instruction holding register with load, flush and ready handshake.
module fetch_slot
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic            i_flush,
   input  logic [XLEN-1:0] i_data,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_ready,
   output logic            o_valid,
   output logic [XLEN-1:0] o_data,
   output logic [XLEN-1:0] o_pc
);

   logic            r_valid;
   logic [XLEN-1:0] r_data;
   logic [XLEN-1:0] r_pc;

   // Flush wins over load so a redirect never leaves a stale word behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_pc    <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_pc    <= i_pc;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_pc    = r_pc;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, sequences instruction memory and
// hands fetched words to decode through a one-entry slot.
module inst_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned     MEM_WORDS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   input  logic            inst_ready,
   output logic            fault
);

   function automatic logic legal(input logic [XLEN-1:0] a);
      return (a[1:0] == 2'b00) && ((a >> 2) < XLEN'(MEM_WORDS));
   endfunction

   fetch_state_t    r_state, w_state_nxt;
   logic [XLEN-1:0] r_pc, w_pc_nxt;
   logic            r_fault, w_fault_nxt;
   logic            w_load, w_flush, w_slot_free;

   assign w_slot_free = !inst_valid || inst_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FETCH;
         r_pc    <= RESET_PC;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_fault <= w_fault_nxt;
      end
   end

   // Redirect outranks everything, including halt in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_fault_nxt = r_fault;
      w_load      = 1'b0;
      w_flush     = 1'b0;
      if (redirect_valid) begin
         w_flush = 1'b1;
         if (legal(redirect_pc)) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = FETCH;
            w_fault_nxt = 1'b0;
         end else begin
            w_state_nxt = FAULT;
            w_fault_nxt = 1'b1;
         end
      end else begin
         case (r_state)
            FETCH: begin
               if (!legal(r_pc)) begin
                  w_state_nxt = FAULT;
                  w_fault_nxt = 1'b1;
               end else if (halt) begin
                  w_state_nxt = HALTED;
               end else if (w_slot_free) begin
                  w_load   = 1'b1;
                  w_pc_nxt = r_pc + XLEN'(WORD_BYTES);
               end
            end
            HALTED:  w_state_nxt = HALTED;
            FAULT:   w_fault_nxt = 1'b1;
            default: w_state_nxt = FAULT;
         endcase
      end
   end

   fetch_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_flush (w_flush),
      .i_data  (imem_rdata),
      .i_pc    (r_pc),
      .i_ready (inst_ready),
      .o_valid (inst_valid),
      .o_data  (inst_data),
      .o_pc    (inst_pc)
   );

   assign imem_addr = r_pc;
   assign fault     = r_fault;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl with a word-index memory model.
module tb_inst_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        fault;

   int n_checks = 0;
   int n_errors = 0;

   inst_fetch_ctrl #(.RESET_PC(32'h0), .MEM_WORDS(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .fault          (fault)
   );

   always #5 clk = ~clk;

   assign imem_rdata = 32'h1000_0000 + (imem_addr >> 2);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_inst(input string tag, input logic [31:0] pc);
      chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
      chk({tag, "_pc"}, inst_pc, pc);
      chk({tag, "_data"}, inst_data, 32'h1000_0000 + (pc >> 2));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_addr"}, imem_addr, 32'h0);
      chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
      chk({tag, "_data"}, inst_data, 32'h0);
      chk({tag, "_pc"}, inst_pc, 32'h0);
      chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      halt = 1'b0; inst_ready = 1'b1;
      #1;
      chk_reset("rst0");
      tick(); tick();
      chk_reset("rst1");
      rst_n = 1'b1;

      // streaming, no bubbles
      tick(); chk_inst("s0", 32'h0); chk("s0_addr", imem_addr, 32'h4);
      tick(); chk_inst("s1", 32'h4);
      tick(); chk_inst("s2", 32'h8); chk("s2_addr", imem_addr, 32'hC);

      // backpressure hold for 3 cycles
      inst_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_inst("bp", 32'h8); chk("bp_addr", imem_addr, 32'hC);
      end
      inst_ready = 1'b1;
      tick(); chk_inst("bp_rel", 32'hC);
      tick(); chk_inst("s4", 32'h10);

      // redirect alongside handshake of 0x10
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      tick(); chk("rd_bub", {31'd0, inst_valid}, 32'd0); chk("rd_addr", imem_addr, 32'h40);
      redirect_valid = 1'b0;
      tick(); chk_inst("rd_tgt", 32'h40);

      // illegal redirects: misaligned then out of range
      redirect_valid = 1'b1; redirect_pc = 32'h42;
      tick(); chk("mis_fault", {31'd0, fault}, 32'd1); chk("mis_valid", {31'd0, inst_valid}, 32'd0);
      redirect_pc = 32'h80;
      tick(); chk("oor_fault", {31'd0, fault}, 32'd1); chk("oor_valid", {31'd0, inst_valid}, 32'd0);
      redirect_valid = 1'b0;
      tick(); chk("flt_hold", {31'd0, fault}, 32'd1); chk("flt_valid", {31'd0, inst_valid}, 32'd0);
      redirect_valid = 1'b1; redirect_pc = 32'h4;
      tick(); chk("rec_fault", {31'd0, fault}, 32'd0); chk("rec_valid", {31'd0, inst_valid}, 32'd0);
      redirect_valid = 1'b0;
      tick(); chk_inst("rec", 32'h4);

      // run off the end of memory
      redirect_valid = 1'b1; redirect_pc = 32'h78;
      tick(); redirect_valid = 1'b0;
      tick(); chk_inst("end0", 32'h78);
      tick(); chk_inst("end1", 32'h7C); chk("end1_fault", {31'd0, fault}, 32'd0);
      inst_ready = 1'b0;
      tick(); chk("end_fault", {31'd0, fault}, 32'd1); chk_inst("end_hold", 32'h7C);
      inst_ready = 1'b1;
      tick(); chk("end_drain", {31'd0, inst_valid}, 32'd0); chk("end_fault2", {31'd0, fault}, 32'd1);

      // halt with a held slot
      redirect_valid = 1'b1; redirect_pc = 32'h18;
      tick(); redirect_valid = 1'b0; chk("h_fault", {31'd0, fault}, 32'd0);
      tick(); chk_inst("h0", 32'h18);
      tick(); chk_inst("h1", 32'h1C);
      tick(); chk_inst("h2", 32'h20);
      inst_ready = 1'b0; halt = 1'b1;
      tick(); chk_inst("h_hold0", 32'h20); chk("h_addr0", imem_addr, 32'h24);
      tick(); chk_inst("h_hold1", 32'h20);
      inst_ready = 1'b1; halt = 1'b0;
      tick(); chk("h_drain", {31'd0, inst_valid}, 32'd0);
      tick(); chk("h_idle", {31'd0, inst_valid}, 32'd0); chk("h_addr1", imem_addr, 32'h24);

      // redirect out of halt, with halt ignored in the same cycle
      redirect_valid = 1'b1; redirect_pc = 32'h0; halt = 1'b1;
      tick(); redirect_valid = 1'b0; halt = 1'b0;
      chk("hr_addr", imem_addr, 32'h0); chk("hr_valid", {31'd0, inst_valid}, 32'd0);
      tick(); chk_inst("hr0", 32'h0);
      tick(); chk_inst("hr1", 32'h4);

      // asynchronous reset mid-stream
      rst_n = 1'b0;
      #1;
      chk_reset("arst");
      tick(); chk_reset("arst_hold");
      rst_n = 1'b1;
      tick(); chk_inst("post_rst", 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction fetch controller that sequences the instruction memory. It owns the program counter and drives the instruction memory's byte address each cycle. It captures the returned word into a single-entry output slot and hands it to decode over a valid/ready handshake. Branch/jump redirects, halt, and illegal fetch addresses are handled here, so decode never sees stale or out-of-range instructions.

## Interface
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- MEM_WORDS, 32, number of 32-bit words in instruction memory; legal addresses are 0 .. 4*MEM_WORDS-4.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  byte address to instruction memory; equals the PC register (no combinational path from inputs).
- imem_rdata  in  32  instruction word; combinational read valid in the same cycle as imem_addr.
- redirect_valid  in  1  branch/jump taken; flush and restart at redirect_pc.
- redirect_pc  in  32  target byte address.
- halt  in  1  stop fetching after the current slot contents drain.
- inst_valid  out  1  output slot holds an instruction.
- inst_data  out  32  instruction word.
- inst_pc  out  32  byte address inst_data was fetched from.
- inst_ready  in  1  decode accepts; a transfer occurs when inst_valid && inst_ready.
- fault  out  1  sticky illegal-fetch flag.

## Operation
- States: FETCH, HALTED, FAULT. Reset state is FETCH.
- Register pc. legal(a) = (a[1:0]==0) && (a>>2 < MEM_WORDS).
- Slot free = !inst_valid || inst_ready.
- Priority per cycle, highest first: reset, redirect, fault check, halt, fetch.
- Redirect (any state):
  - Slot is cleared next cycle; a same-cycle handshake still counts as accepted.
  - If legal(redirect_pc): pc <= redirect_pc, state <= FETCH, fault <= 0.
  - Otherwise: state <= FAULT, fault <= 1.
  - halt asserted in the same cycle is ignored.
- FETCH, no redirect:
  - If !legal(pc): state <= FAULT, fault <= 1, slot unchanged (may still drain).
  - Else if halt: state <= HALTED, no load; the slot drains normally.
  - Else if slot free: inst_data <= imem_rdata, inst_pc <= pc, inst_valid <= 1, pc <= pc+4.
  - Else: hold all.
- Sequential wrap: pc+4 past the last word is not wrapped. The next cycle faults through the legal() check.
- HALTED: pc frozen, no loads. Exits only through a redirect.
- FAULT: no loads, fault held at 1. Exits only through reset or a legal redirect.
- pc arithmetic is 32-bit modulo; the only alignment source is redirect_pc.

## Timing
- Reset values: pc=RESET_PC, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, fault=0, state=FETCH.
- Fetch latency: 1 cycle from pc to inst_valid.
  - First inst_valid rises at the first rising edge after rst_n deassertion.
- Throughput: 1 instruction/cycle while inst_ready=1.
- Redirect penalty: inst_valid=0 for exactly 1 cycle, then target instruction valid.
- Backpressure: inst_data and inst_pc are stable while inst_valid && !inst_ready.
- Reset mid-operation: asynchronous return to reset values, regardless of state or slot contents.

## Structure
- Shared package fetch_pkg:
  - state enum (FETCH, HALTED, FAULT)
  - WORD_BYTES=4
  - XLEN=32
- One sub-module, fetch_slot: a valid/data/pc holding register with load, flush and ready handshake.
- The controller FSM and PC live in inst_fetch_ctrl. Instruction memory is instantiated outside and wired through imem_addr/imem_rdata.

## Test plan
- Reset release, RESET_PC=0, memory word k = 32'h1000_0000+k, inst_ready=1 -> inst_pc = 0,4,8,… on consecutive cycles with matching data, no bubbles.
- Hold inst_ready=0 for 3 cycles while inst_pc=8 -> inst_data/inst_pc stable at word 2, imem_addr stays 12. Release -> pc 12 valid the next cycle.
- redirect_valid with redirect_pc=0x40 in the same cycle as a handshake at pc 0x10 -> 0x10 accepted, 1 bubble cycle, then inst_pc=0x40.
- redirect_pc=0x42, then redirect_pc=0x80 with MEM_WORDS=32 -> fault=1 and no valid instruction for both. Then redirect_pc=0x4 -> fault=0, inst_pc=0x4 one cycle later.
- Sequential run to pc 0x7C with MEM_WORDS=32 -> 0x7C delivered, then fault=1, inst_valid falls after the final handshake.
- halt while the slot holds pc 0x20 and inst_ready=0 -> 0x20 held until accepted, then no further fetch. Redirect to 0 -> resumes at 0. Assert rst_n=0 mid-stream -> all outputs return to reset values immediately.
